uart_rx_buf_con: RTL and testbench
==================================

Name: uart_rx_buf_con

Overview:
Line assembler on the receive side of the keyboard/debug UART link. It consumes bytes from the UART receiver and packs the payload of each text line into a right-aligned 32-bit word with a byte count. A line is up to 4 payload bytes, optionally split by spaces, and ends with CR or LF. Each completed line is offered on a valid/ready port to downstream control logic. It is the inverse of the transmit-side buffer controller, which emits {b3 b2 SP b1 b0 CR LF}.

Parameters:
MAX_BYTES, 4, maximum payload bytes per line; legal values 1..4.
STRIP_SPACE, 1, 1 = discard 8'd32 inside a line; 0 = treat space as a payload byte.

Ports:
clk  in  1  system clock; all state on posedge.
rst_n  in  1  asynchronous active-low reset.
rx_data  in  8  byte from the UART receiver; valid only when rx_valid=1.
rx_valid  in  1  one-cycle strobe per received byte.
rbuf  out  32  assembled line; last received payload byte in [7:0]; unused upper bytes are 0.
rcount  out  3  number of payload bytes in rbuf, 1..MAX_BYTES.
rvalid  out  1  rbuf/rcount hold a line not yet taken.
rready  in  1  consumer accepts; transfer occurs when rvalid & rready.
overflow  out  1  one-cycle pulse when a line exceeds MAX_BYTES and is discarded.
overrun  out  1  one-cycle pulse when a completed line is dropped because the output is still occupied.

Behaviour:
- Reset (async assert, sync deassert by the source): state=IDLE; acc=0; cnt=0; rbuf=0; rcount=0; rvalid=0; overflow=0; overrun=0.
- Byte classes: TERM = 8'd13 or 8'd10. SPACE = 8'd32 when STRIP_SPACE=1. DATA = every other byte.
- State IDLE (no bytes accumulated):
  - DATA: acc <= {24'd0, rx_data}, cnt <= 1, go to COLLECT.
  - TERM or SPACE: ignored. Empty lines and the LF of a CR-LF pair produce no output.
- State COLLECT:
  - DATA with cnt < MAX_BYTES: acc <= {acc[23:0], rx_data}, cnt <= cnt+1.
  - DATA with cnt == MAX_BYTES: pulse overflow, clear acc and cnt, go to DISCARD.
  - SPACE: ignored; state, acc and cnt are unchanged.
  - TERM: complete the line (see below), clear acc and cnt, go to IDLE.
- State DISCARD: all bytes are ignored until a TERM arrives, then go to IDLE. No output is produced for the discarded line.
- Line completion, registered in the same cycle as the TERM strobe, so rvalid rises 1 cycle after the rx_valid carrying the TERM:
  - If the output slot is free, or is being drained this cycle (rvalid & rready): rbuf <= acc, rcount <= cnt, rvalid <= 1.
  - Otherwise: keep the old rbuf/rcount and pulse overrun. The old line is never overwritten.
- Output handshake:
  - rvalid stays high and rbuf/rcount stay stable until rvalid & rready.
  - On that cycle rvalid <= 0 unless a new completion loads in the same cycle.
  - rready while rvalid=0 has no effect.
- Packing: acc is a 32-bit left shift by 8 per DATA byte. Bytes above cnt stay 0 because acc is cleared at line start.
- Only rx_valid cycles advance the state machine. rx_data is ignored otherwise.
- overflow and overrun are pulses exactly 1 cycle wide and are never asserted simultaneously.
- Reset asserted mid-line or with rvalid=1: all state clears immediately and the pending line is lost.

Test Plan:
- Feed "AB CD\r\n" (41,42,20,43,44,0D,0A) with rready=1 -> one rvalid pulse; rbuf=32'h41424344, rcount=4. The trailing LF gives no second output.
- Feed "7\n" -> rbuf=32'h00000037, rcount=1. Then feed "\r\n\r" -> no further rvalid.
- Feed "12345\n" with MAX_BYTES=4 -> overflow pulses on byte '5' and no rvalid. The following "9\n" yields rbuf=32'h39, rcount=1.
- Hold rready=0; feed "AA\n" then "BB\n" -> rbuf=32'h4141 stays with rcount=2, overrun pulses once on the second LF. Raise rready -> rvalid drops the next cycle.
- With rvalid=1, assert rready in the same cycle as the TERM of "C\n" -> old line is taken, rvalid stays 1, rbuf becomes 32'h43 with no overrun. Repeat with STRIP_SPACE=0 on "A B\n" -> rbuf=32'h412042, rcount=3.
- Assert rst_n=0 after "XY" mid-line while rvalid=1 -> all outputs 0 asynchronously. After release, "Z\n" -> rbuf=32'h5A, rcount=1.

Source files
------------

// File: rtl/uart_rx_buf_con_if.sv
// uart_rx_buf_con_if: byte input strobe and line-output valid/ready bundle for the UART line assembler.
interface uart_rx_buf_con_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] rbuf;
    logic [2:0]  rcount;
    logic        rvalid;
    logic        rready;
    logic        overflow;
    logic        overrun;
    modport master (output rx_data, rx_valid, rready, input rbuf, rcount, rvalid, overflow, overrun);
    modport slave (input rx_data, rx_valid, rready, output rbuf, rcount, rvalid, overflow, overrun);
endinterface

// File: rtl/uart_rx_buf_con.sv
// uart_rx_buf_con: packs CR/LF-terminated UART text lines of up to MAX_BYTES payload bytes
// into a right-aligned word offered on a valid/ready port.
module uart_rx_buf_con #(
    parameter int MAX_BYTES   = 4,
    parameter bit STRIP_SPACE = 1
) (
    input logic               clk,
    input logic               rst_n,
    uart_rx_buf_con_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;
    state_t      state, state_nx;
    logic [31:0] acc, acc_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        done, ovf;
    logic        is_term, is_data, take, free;
    assign is_term = bus.rx_data == 8'd13 || bus.rx_data == 8'd10;
    assign is_data = !is_term && !(STRIP_SPACE && bus.rx_data == 8'd32);
    assign take    = bus.rvalid && bus.rready;
    assign free    = !bus.rvalid || take;
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        done     = 1'b0;
        ovf      = 1'b0;
        if (bus.rx_valid) begin
            case (state)
                IDLE: if (is_data) begin
                    acc_nx   = {24'd0, bus.rx_data};
                    cnt_nx   = 3'd1;
                    state_nx = COLLECT;
                end
                COLLECT: if (is_term) begin
                    done     = 1'b1;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (is_data) begin
                    ovf      = cnt == 3'(MAX_BYTES);
                    acc_nx   = ovf ? '0 : {acc[23:0], bus.rx_data};
                    cnt_nx   = ovf ? '0 : cnt + 3'd1;
                    state_nx = ovf ? DISCARD : COLLECT;
                end
                default: state_nx = is_term ? IDLE : DISCARD;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            bus.rbuf     <= '0;
            bus.rcount   <= '0;
            bus.rvalid   <= 1'b0;
            bus.overflow <= 1'b0;
            bus.overrun  <= 1'b0;
        end else begin
            state        <= state_nx;
            acc          <= acc_nx;
            cnt          <= cnt_nx;
            bus.overflow <= ovf;
            bus.overrun  <= done && !free;
            // a completion may reuse the slot in the same cycle it is drained
            if (done && free) begin
                bus.rbuf   <= acc;
                bus.rcount <= cnt;
                bus.rvalid <= 1'b1;
            end else if (take) begin
                bus.rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_buf_con.sv
// tb_uart_rx_buf_con: directed line-assembly checks on a space-stripping and a space-keeping instance.
module tb_uart_rx_buf_con;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int errors = 0;
    uart_rx_buf_con_if a ();
    uart_rx_buf_con_if b ();
    uart_rx_buf_con #(.MAX_BYTES(4), .STRIP_SPACE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    uart_rx_buf_con #(.MAX_BYTES(4), .STRIP_SPACE(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        a.rx_data = d;
        a.rx_valid = 1'b1;
        @(negedge clk);
        a.rx_valid = 1'b0;
        a.rx_data = 8'hxx;
    endtask

    task automatic send_b(input logic [7:0] d);
        b.rx_data = d;
        b.rx_valid = 1'b1;
        @(negedge clk);
        b.rx_valid = 1'b0;
        b.rx_data = 8'hxx;
    endtask

    initial begin
        a.rx_data = '0; a.rx_valid = 1'b0; a.rready = 1'b0;
        b.rx_data = '0; b.rx_valid = 1'b0; b.rready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rbuf", a.rbuf, 32'h0);
        chk("rst_rcount", 32'(a.rcount), 32'd0);
        chk("rst_rvalid", 32'(a.rvalid), 32'd0);
        chk("rst_overflow", 32'(a.overflow), 32'd0);
        chk("rst_overrun", 32'(a.overrun), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        a.rready = 1'b1;
        send(8'h41); send(8'h42); send(8'h20); send(8'h43); send(8'h44); send(8'h0D);
        chk("abcd_rvalid", 32'(a.rvalid), 32'd1);
        chk("abcd_rbuf", a.rbuf, 32'h41424344);
        chk("abcd_rcount", 32'(a.rcount), 32'd4);
        send(8'h0A);
        chk("abcd_lf_no_second", 32'(a.rvalid), 32'd0);

        send(8'h37); send(8'h0A);
        chk("seven_rvalid", 32'(a.rvalid), 32'd1);
        chk("seven_rbuf", a.rbuf, 32'h00000037);
        chk("seven_rcount", 32'(a.rcount), 32'd1);
        send(8'h0D); send(8'h0A); send(8'h0D);
        chk("empty_lines", 32'(a.rvalid), 32'd0);

        send(8'h31); send(8'h32); send(8'h33); send(8'h34);
        chk("ovf_not_yet", 32'(a.overflow), 32'd0);
        send(8'h35);
        chk("ovf_pulse", 32'(a.overflow), 32'd1);
        send(8'h0A);
        chk("ovf_one_cycle", 32'(a.overflow), 32'd0);
        chk("ovf_no_line", 32'(a.rvalid), 32'd0);
        send(8'h39); send(8'h0A);
        chk("nine_rbuf", a.rbuf, 32'h39);
        chk("nine_rcount", 32'(a.rcount), 32'd1);
        @(negedge clk);
        a.rready = 1'b0;

        send(8'h41); send(8'h41); send(8'h0A);
        chk("aa_rvalid", 32'(a.rvalid), 32'd1);
        chk("aa_rbuf", a.rbuf, 32'h4141);
        send(8'h42); send(8'h42);
        chk("aa_held", a.rbuf, 32'h4141);
        send(8'h0A);
        chk("bb_overrun", 32'(a.overrun), 32'd1);
        chk("bb_keep_rbuf", a.rbuf, 32'h4141);
        chk("bb_keep_rcount", 32'(a.rcount), 32'd2);
        @(negedge clk);
        chk("overrun_one_cycle", 32'(a.overrun), 32'd0);
        chk("aa_still_valid", 32'(a.rvalid), 32'd1);
        a.rready = 1'b1;
        @(negedge clk);
        chk("aa_drained", 32'(a.rvalid), 32'd0);
        a.rready = 1'b0;

        send(8'h41); send(8'h0A);
        chk("a_loaded", a.rbuf, 32'h41);
        send(8'h43);
        a.rready = 1'b1;
        send(8'h0A);
        chk("c_rvalid_kept", 32'(a.rvalid), 32'd1);
        chk("c_rbuf", a.rbuf, 32'h43);
        chk("c_no_overrun", 32'(a.overrun), 32'd0);
        @(negedge clk);
        chk("c_drained", 32'(a.rvalid), 32'd0);
        a.rready = 1'b0;

        send_b(8'h41); send_b(8'h20); send_b(8'h42); send_b(8'h0A);
        chk("b_space_rbuf", b.rbuf, 32'h412042);
        chk("b_space_rcount", 32'(b.rcount), 32'd3);

        send(8'h41); send(8'h0A);
        send(8'h58); send(8'h59);
        chk("pre_rst_rvalid", 32'(a.rvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rvalid", 32'(a.rvalid), 32'd0);
        chk("async_rbuf", a.rbuf, 32'h0);
        chk("async_rcount", 32'(a.rcount), 32'd0);
        chk("async_b_rvalid", 32'(b.rvalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h5A); send(8'h0A);
        chk("z_rvalid", 32'(a.rvalid), 32'd1);
        chk("z_rbuf", a.rbuf, 32'h5A);
        chk("z_rcount", 32'(a.rcount), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
